// File: rtl/ev2_rx_buffer.sv
// ev2 receive buffer: packs 16-bit event words into 32-bit pairs, queues them and
// presents them first-word-fall-through. Define EV2_RX_OVERFLOW_EN to enable overflow_o.
module ev2_rx_buffer #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] ev2_dat_i,
    input  logic        ev2_wr_i,
    output logic [15:0] ev2_count_o,
    output logic        ev2_full_o,
    input  logic        ev2_rst_i,
    output logic        ev2_rst_ack_o,
    output logic [31:0] dat_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overflow_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 2;
    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(2 * DEPTH);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [31:0]           mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   used_reg;
    logic [DEPTH_LOG2:0]   used_next;
    logic [DEPTH_LOG2:0]   staged;
    logic                  half_reg;
    logic                  half_next;
    logic [15:0]           pack_reg;
    logic [31:0]           pre_data_reg;
    logic                  pre_valid_reg;
    logic [31:0]           out_data_reg;
    logic                  out_valid_reg;
    logic [15:0]           count_reg;
    logic                  full_reg;
    logic                  ack_reg;
    logic [CNT_W-1:0]      free_next;

    logic wr_accept;
    logic push;
    logic pop;
    logic pre_move;
    logic ram_empty;
    logic ram_rd;

    assign wr_accept = (state_reg == RUN) && ev2_wr_i && !full_reg;
    assign push      = wr_accept && half_reg;
    assign pop       = out_valid_reg && ready_i;
    assign pre_move  = pre_valid_reg && (!out_valid_reg || pop);

    // used_reg counts every held entry, including the prefetch and output stages
    assign staged    = (DEPTH_LOG2 + 1)'(pre_valid_reg) + (DEPTH_LOG2 + 1)'(out_valid_reg);
    assign ram_empty = (used_reg == staged);
    assign ram_rd    = !ram_empty && (!pre_valid_reg || pre_move);

    assign half_next = wr_accept ? !half_reg : half_reg;
    assign used_next = used_reg + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
    assign free_next = CAPACITY - {used_next, 1'b0} - CNT_W'(half_next);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (ev2_rst_i) state_next = FLUSH;
            FLUSH:   state_next = ACK;
            ACK:     if (!ev2_rst_i) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Storage array with registered read feeding the prefetch stage
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= {ev2_dat_i, pack_reg};
        end
        if (ram_rd) begin
            pre_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= RUN;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            used_reg      <= '0;
            half_reg      <= 1'b0;
            pack_reg      <= '0;
            pre_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            count_reg     <= 16'(CAPACITY);
            full_reg      <= 1'b0;
            ack_reg       <= 1'b0;
        end else if (state_reg == FLUSH) begin
            state_reg     <= state_next;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            used_reg      <= '0;
            half_reg      <= 1'b0;
            pre_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            count_reg     <= 16'(CAPACITY);
            full_reg      <= 1'b0;
            ack_reg       <= 1'b1;
        end else begin
            state_reg <= state_next;
            ack_reg   <= (state_next == ACK);
            used_reg  <= used_next;
            half_reg  <= half_next;
            count_reg <= 16'(free_next);
            full_reg  <= (free_next == '0);
            if (wr_accept && !half_reg) begin
                pack_reg <= ev2_dat_i;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                pre_valid_reg <= 1'b1;
            end else if (pre_move) begin
                pre_valid_reg <= 1'b0;
            end
            // Output stage refills on the same edge it is popped to keep one entry per cycle
            if (pre_move) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= pre_data_reg;
            end else if (pop) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef EV2_RX_OVERFLOW_EN
    logic overflow_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_reg <= 1'b0;
        end else if (state_reg == FLUSH) begin
            overflow_reg <= 1'b0;
        end else if ((state_reg == RUN) && ev2_wr_i && full_reg) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow_o = overflow_reg;
`else
    assign overflow_o = 1'b0;
`endif

    assign ev2_count_o   = count_reg;
    assign ev2_full_o    = full_reg;
    assign ev2_rst_ack_o = ack_reg;
    assign dat_o         = out_data_reg;
    assign valid_o       = out_valid_reg;

endmodule

// File: tb/tb_ev2_rx_buffer.sv
// Bench for ev2_rx_buffer: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_ev2_rx_buffer;
    localparam int DL2     = 8;
    localparam int ENTRIES = 1 << DL2;
`ifdef EV2_RX_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int RUN_P   = 0;
    localparam int FLUSH_P = 1;
    localparam int ACK_P   = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] ev2_dat_i = '0;
    logic        ev2_wr_i = 1'b0;
    logic [15:0] ev2_count_o;
    logic        ev2_full_o;
    logic        ev2_rst_i = 1'b0;
    logic        ev2_rst_ack_o;
    logic [31:0] dat_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    ev2_rx_buffer #(.DEPTH_LOG2(DL2)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ev2_dat_i    (ev2_dat_i),
        .ev2_wr_i     (ev2_wr_i),
        .ev2_count_o  (ev2_count_o),
        .ev2_full_o   (ev2_full_o),
        .ev2_rst_i    (ev2_rst_i),
        .ev2_rst_ack_o(ev2_rst_ack_o),
        .dat_o        (dat_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pairs queued with the edge they completed on; an entry shows
    // on the output two edges after completion, or on the edge its predecessor leaves.
    logic [31:0] q_dat[$];
    int          q_edge[$];
    bit          m_valid = 1'b0;
    bit          m_half  = 1'b0;
    bit          m_ovf   = 1'b0;
    logic [15:0] m_pack  = '0;
    int          m_phase = RUN_P;
    int          edge_n  = 0;

    function automatic int m_count();
        return 2 * (ENTRIES - q_dat.size()) - int'(m_half);
    endfunction

    task automatic model_clear();
        q_dat.delete();
        q_edge.delete();
        m_valid = 1'b0;
        m_half  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step();
        bit pop_now;
        bit acc;
        bit drop;
        edge_n++;
        if (rst_i) begin
            model_clear();
            m_phase = RUN_P;
            return;
        end
        if (m_phase == FLUSH_P) begin
            model_clear();
            m_phase = ACK_P;
            return;
        end
        pop_now = m_valid && ready_i;
        acc     = (m_phase == RUN_P) && ev2_wr_i && (m_count() != 0);
        drop    = (m_phase == RUN_P) && ev2_wr_i && (m_count() == 0);
        if (pop_now) begin
            $display("xfer %08h", q_dat[0]);
            void'(q_dat.pop_front());
            void'(q_edge.pop_front());
            m_valid = 1'b0;
        end
        if (acc) begin
            if (!m_half) begin
                m_pack = ev2_dat_i;
                m_half = 1'b1;
            end else begin
                q_dat.push_back({ev2_dat_i, m_pack});
                q_edge.push_back(edge_n);
                m_half = 1'b0;
            end
        end
        if (drop && OVF_EN) m_ovf = 1'b1;
        if (!m_valid && q_dat.size() > 0 && q_edge[0] + 2 <= edge_n) m_valid = 1'b1;
        if (m_phase == RUN_P && ev2_rst_i) m_phase = FLUSH_P;
        else if (m_phase == ACK_P && !ev2_rst_i) m_phase = RUN_P;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("valid", valid_o, m_valid);
            check("ack", ev2_rst_ack_o, (m_phase == ACK_P));
            check("count", ev2_count_o, m_count());
            check("full", ev2_full_o, (m_count() == 0));
            check("overflow", overflow_o, m_ovf);
            if (m_valid) check("dat", dat_o, q_dat[0]);
        end
    end

    task automatic drive(input logic wr, input logic [15:0] d);
        ev2_wr_i  = wr;
        ev2_dat_i = d;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("rst_count", ev2_count_o, 32'd512);
        check("rst_full", ev2_full_o, 1'b0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ack", ev2_rst_ack_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        check("rst_dat", dat_o, 32'h0);
        rst_i = 1'b0;
        @(negedge clk);

        // Single pair with downstream ready
        ready_i = 1'b1;
        drive(1'b1, 16'h1111);
        check("a_count1", ev2_count_o, 32'd511);
        drive(1'b1, 16'h2222);
        check("a_count2", ev2_count_o, 32'd510);
        drive(1'b0, 16'h0000);
        check("a_valid_early", valid_o, 1'b0);
        @(negedge clk);
        check("a_valid", valid_o, 1'b1);
        check("a_dat", dat_o, 32'h22221111);
        @(negedge clk);
        check("a_popped", valid_o, 1'b0);
        check("a_count3", ev2_count_o, 32'd512);

        // Fill with downstream stalled
        ready_i = 1'b0;
        for (int i = 0; i < 512; i++) drive(1'b1, 16'(16'h1000 + i));
        check("b_full", ev2_full_o, 1'b1);
        check("b_count", ev2_count_o, 32'd0);
        drive(1'b1, 16'hDEAD);
        check("b_ovf", overflow_o, OVF_EN);
        check("b_count_drop", ev2_count_o, 32'd0);
        check("b_head", dat_o, 32'h10011000);

        // Drain while writing continuously; first write hits full and is dropped
        ready_i = 1'b1;
        for (int i = 0; i < 301; i++) drive(1'b1, 16'(16'h1200 + i));
        for (int i = 0; i < 300; i++) drive(1'b0, 16'h0000);
        check("c_drained", valid_o, 1'b0);
        check("c_count", ev2_count_o, 32'd512);

        // Half word then one-cycle flush pulse
        drive(1'b1, 16'hABCD);
        check("d_count_half", ev2_count_o, 32'd511);
        ev2_rst_i = 1'b1;
        drive(1'b0, 16'h0000);
        check("d_ack_flush", ev2_rst_ack_o, 1'b0);
        ev2_rst_i = 1'b0;
        @(negedge clk);
        check("d_ack", ev2_rst_ack_o, 1'b1);
        check("d_count", ev2_count_o, 32'd512);
        check("d_ovf", overflow_o, 1'b0);
        @(negedge clk);
        check("d_ack_low", ev2_rst_ack_o, 1'b0);
        repeat (4) @(negedge clk);
        check("d_no_half", valid_o, 1'b0);

        // Long flush request with writes attempted throughout
        ev2_rst_i = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 16'(16'h3000 + i));
        check("e_ack_hold", ev2_rst_ack_o, 1'b1);
        check("e_count", ev2_count_o, 32'd512);
        check("e_ovf", overflow_o, 1'b0);
        ev2_rst_i = 1'b0;
        drive(1'b0, 16'h0000);
        check("e_ack_rel", ev2_rst_ack_o, 1'b0);
        drive(1'b1, 16'h0001);
        drive(1'b1, 16'h0002);
        drive(1'b0, 16'h0000);
        @(negedge clk);
        check("e_dat", dat_o, 32'h00020001);

        // Asynchronous reset mid-pair with valid output
        ready_i = 1'b0;
        for (int i = 0; i < 7; i++) drive(1'b1, 16'(16'h4000 + i));
        check("f_valid_pre", valid_o, 1'b1);
        ev2_wr_i  = 1'b1;
        ev2_dat_i = 16'h4007;
        #2 rst_i = 1'b1;
        #1;
        check("f_valid", valid_o, 1'b0);
        check("f_dat", dat_o, 32'h0);
        check("f_count", ev2_count_o, 32'd512);
        check("f_full", ev2_full_o, 1'b0);
        check("f_ack", ev2_rst_ack_o, 1'b0);
        check("f_ovf", overflow_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        drive(1'b1, 16'h0A0B);
        drive(1'b1, 16'h0C0D);
        drive(1'b0, 16'h0000);
        @(negedge clk);
        check("f_after_valid", valid_o, 1'b1);
        check("f_after_dat", dat_o, 32'h0C0D0A0B);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
